// File: rtl/sms_clk_pkg.sv
// Shared types and defaults for the Master System clock-enable generator.
package sms_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int unsigned MASTER_HZ       = 53693175;
    localparam int          DEF_CPU_DIV     = 15;
    localparam int          DEF_VDP_DIV     = 10;
    localparam int          DEF_PSG_DIV     = 16;
    localparam int          DEF_HOLD_CYCLES = 1024;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sms_ce_div.sv
// Divide-by-DIV single-cycle enable generator. Counts only when en_in is
// high; ce_out marks the enabled cycle on which the count wraps.
module sms_ce_div
    import sms_clk_pkg::*;
#(
    parameter int DIV = DEF_CPU_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en_in,
    output logic ce_out
);

    localparam int            CW   = cnt_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    // Modulo-DIV counter, held at zero while cleared so the first enabled
    // cycle after clearing sees a count of zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en_in) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Gated by clr so a stale terminal count never leaks out after RUN ends.
    assign ce_out = en_in & ~clr & (cnt_q == LAST);

endmodule

// File: rtl/sms_clk_en_gen.sv
// Lock-qualified system reset and SMS clock enables (CPU, VDP, PSG) derived
// from the 53.693175 MHz PLL output.
module sms_clk_en_gen
    import sms_clk_pkg::*;
#(
    parameter int CPU_DIV     = DEF_CPU_DIV,
    parameter int VDP_DIV     = DEF_VDP_DIV,
    parameter int PSG_DIV     = DEF_PSG_DIV,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    output logic sys_reset,
    output logic ce_cpu,
    output logic ce_vdp,
    output logic ce_psg,
    output logic running
);

    localparam int            HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk_s;
    state_t                 state_q, state_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic                   div_clr;

    // Bring the asynchronous lock flag into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end

    assign lk_s = sync_q[SYNC_STAGES-1];

    // Next-state: any low lk_s drops back to WAIT_LOCK; HOLD needs an
    // unbroken run of HOLD_CYCLES locked cycles before releasing.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            HOLD: begin
                hold_d = hold_q + 1'b1;
                if (!lk_s)                   state_d = WAIT_LOCK;
                else if (hold_q == HOLD_LAST) state_d = RUN;
            end
            RUN: begin
                if (!lk_s) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // State, hold counter and state-decoded outputs registered together so
    // sys_reset and running change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_LOCK;
            hold_q    <= '0;
            sys_reset <= 1'b1;
            running   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            sys_reset <= (state_d != RUN);
            running   <= (state_d == RUN);
        end
    end

    assign div_clr = (state_q != RUN);

    sms_ce_div #(.DIV(CPU_DIV)) u_cpu_div (
        .clk(clk), .rst(rst), .clr(div_clr), .en_in(1'b1),   .ce_out(ce_cpu)
    );

    sms_ce_div #(.DIV(VDP_DIV)) u_vdp_div (
        .clk(clk), .rst(rst), .clr(div_clr), .en_in(1'b1),   .ce_out(ce_vdp)
    );

    // PSG rate is a sub-division of the CPU enable, so it stays phase-locked
    // to ce_cpu.
    sms_ce_div #(.DIV(PSG_DIV)) u_psg_div (
        .clk(clk), .rst(rst), .clr(div_clr), .en_in(ce_cpu), .ce_out(ce_psg)
    );

endmodule

// File: tb/tb_sms_clk_en_gen.sv
// Scoreboard bench for sms_clk_en_gen: a behavioural model pushes expected
// outputs per cycle, a monitor pops and compares them.
module tb_sms_clk_en_gen;

    localparam int CPU_DIV     = 15;
    localparam int VDP_DIV     = 10;
    localparam int PSG_DIV     = 16;
    localparam int HOLD_CYCLES = 1024;
    localparam int SYNC_STAGES = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pll_locked = 1'b0;
    logic sys_reset, ce_cpu, ce_vdp, ce_psg, running;

    typedef struct packed {
        logic sys_reset;
        logic running;
        logic ce_cpu;
        logic ce_vdp;
        logic ce_psg;
    } obs_t;

    typedef struct {
        string  name;
        longint got;
        longint exp;
    } dchk_t;

    obs_t   exp_q[$];
    dchk_t  dir_q[$];
    bit     hist[$];
    longint streak;
    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;

    always #5 clk = ~clk;

    sms_clk_en_gen #(
        .CPU_DIV(CPU_DIV), .VDP_DIV(VDP_DIV), .PSG_DIV(PSG_DIV),
        .HOLD_CYCLES(HOLD_CYCLES), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .sys_reset(sys_reset), .ce_cpu(ce_cpu), .ce_vdp(ce_vdp),
        .ce_psg(ce_psg), .running(running)
    );

    // Reference model: the system runs once lk_s has been seen high on
    // HOLD_CYCLES+1 consecutive edges; enables are pure functions of the
    // index within the current run.
    task automatic model_push(input bit r, input bit pl);
        obs_t   e;
        bit     lk;
        bit     run;
        longint idx;
        if (r) begin
            hist.delete();
            for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(1'b0);
            streak = 0;
        end else begin
            lk = hist.pop_front();
            hist.push_back(pl);
            streak = lk ? streak + 1 : 0;
        end
        run = (streak >= HOLD_CYCLES + 1);
        idx = streak - (HOLD_CYCLES + 1);
        e.sys_reset = !run;
        e.running   = run;
        e.ce_cpu    = run && (idx % CPU_DIV == CPU_DIV - 1);
        e.ce_vdp    = run && (idx % VDP_DIV == VDP_DIV - 1);
        e.ce_psg    = run && (idx % (CPU_DIV * PSG_DIV) == CPU_DIV * PSG_DIV - 1);
        exp_q.push_back(e);
    endtask

    // One clock: drive on the falling edge, log the expectation, then
    // return just after the rising edge with outputs settled.
    task automatic tick(input bit r, input bit pl);
        @(negedge clk);
        rst        = r;
        pll_locked = pl;
        model_push(r, pl);
        @(posedge clk);
        #1;
    endtask

    task automatic dchk(input string name, input longint got, input longint exp);
        dchk_t d;
        d.name = name;
        d.got  = got;
        d.exp  = exp;
        dir_q.push_back(d);
    endtask

    // Monitor: compares every cycle's outputs and any queued directed checks.
    initial begin
        obs_t  e, a;
        dchk_t d;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{sys_reset, running, ce_cpu, ce_vdp, ce_psg};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d got(rst,run,cpu,vdp,psg)=%b expected=%b",
                             cyc, a, e);
                end
            end
            while (dir_q.size() > 0) begin
                d = dir_q.pop_front();
                checks++;
                if (d.got != d.exp) begin
                    failures++;
                    $display("FAIL %s got=%0d expected=%0d", d.name, d.got, d.exp);
                end
            end
        end
    end

    // Ticks with lock high until sys_reset falls; bounded.
    task automatic wait_release(output int n);
        n = 0;
        do begin
            tick(1'b0, 1'b1);
            n++;
        end while (sys_reset && n < 4000);
    endtask

    initial begin
        int n, first_cpu, first_vdp, first_psg, c_cpu, c_vdp, c_psg, c_both, bad_both;
        int last_cpu, last_vdp, last_psg, bad_sp;
        bit pl;

        // Power-up reset with lock already high.
        repeat (3) tick(1'b1, 1'b1);
        wait_release(n);
        dchk("release_latency", n, SYNC_STAGES + 1 + HOLD_CYCLES);
        dchk("running_at_release", running, 1);

        // Cadence over RUN indices 0..2999.
        c_cpu = 0; c_vdp = 0; c_psg = 0; c_both = 0; bad_both = 0; bad_sp = 0;
        first_cpu = -1; first_vdp = -1; first_psg = -1;
        last_cpu = -1; last_vdp = -1; last_psg = -1;
        for (int i = 0; i < 3000; i++) begin
            if (i > 0) tick(1'b0, 1'b1);
            if (ce_cpu) begin
                if (first_cpu < 0) first_cpu = i;
                if (last_cpu >= 0 && i - last_cpu != CPU_DIV) bad_sp++;
                last_cpu = i; c_cpu++;
            end
            if (ce_vdp) begin
                if (first_vdp < 0) first_vdp = i;
                if (last_vdp >= 0 && i - last_vdp != VDP_DIV) bad_sp++;
                last_vdp = i; c_vdp++;
            end
            if (ce_psg) begin
                if (first_psg < 0) first_psg = i;
                if (last_psg >= 0 && i - last_psg != CPU_DIV * PSG_DIV) bad_sp++;
                last_psg = i; c_psg++;
            end
            if (ce_cpu && ce_vdp) begin
                c_both++;
                if (i % 30 != 29) bad_both++;
            end
        end
        dchk("cpu_count", c_cpu, 200);
        dchk("vdp_count", c_vdp, 300);
        dchk("psg_count", c_psg, 12);
        dchk("cpu_first", first_cpu, 14);
        dchk("vdp_first", first_vdp, 9);
        dchk("psg_first", first_psg, 239);
        dchk("spacing_errors", bad_sp, 0);
        dchk("coincide_count", c_both, 100);
        dchk("coincide_offphase", bad_both, 0);

        // One-cycle lock loss in RUN.
        tick(1'b0, 1'b0);
        n = 1;
        while (!sys_reset && n < 20) begin
            tick(1'b0, 1'b1);
            n++;
        end
        dchk("lockloss_latency", n, SYNC_STAGES + 1);
        dchk("lockloss_ce_off", {ce_cpu, ce_vdp, ce_psg}, 0);
        wait_release(n);
        dchk("relock_latency", n, HOLD_CYCLES + 1);

        // Lock glitch while hold_cnt is 500.
        repeat (2) tick(1'b1, 1'b1);
        for (int i = 0; i < SYNC_STAGES + 501; i++) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        wait_release(n);
        dchk("glitch_release", n + SYNC_STAGES + 502, 2 * SYNC_STAGES + 503 + HOLD_CYCLES);

        // rst at an arbitrary point in RUN, then first ce_cpu of the new RUN.
        repeat ($urandom_range(1, 200)) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        dchk("rst_midrun_vals", {sys_reset, running, ce_cpu, ce_vdp, ce_psg}, 5'b10000);
        wait_release(n);
        first_cpu = -1;
        for (int i = 0; i < 100 && first_cpu < 0; i++) begin
            if (i > 0) tick(1'b0, 1'b1);
            if (ce_cpu) first_cpu = i;
        end
        dchk("first_cpu_after_rst", first_cpu, CPU_DIV - 1);

        // Random lock flapping and occasional resets, checked by the model.
        pl = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1499) == 0) pl = ~pl;
            else if (!pl && $urandom_range(0, 19) == 0) pl = 1'b1;
            tick($urandom_range(0, 999) == 0, pl);
        end

        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
